// File: rtl/rv32i_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit machine word
// and queues {illegal, ir} in a 4-entry FIFO with pop and error counters.
module rv32i_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_op,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ir,
    output logic        out_illegal,
    output logic [15:0] enc_count,
    output logic [7:0]  err_count
);
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OP_OP     = 7'b0110011;
    localparam logic [31:0] NOP_IR    = 32'h0000_0013;

    logic [31:0] raw_ir;
    logic [31:0] enc_ir;
    logic        enc_bad;
    logic        imm_i_ok;
    logic        imm_b_ok;
    logic        imm_j_ok;
    logic        is_shift;

    always_comb begin
        imm_i_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
        imm_b_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
        imm_j_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
        is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
        raw_ir   = NOP_IR;
        enc_bad  = 1'b0;
        case (in_op)
            OP_LUI, OP_AUIPC: begin
                raw_ir  = {in_imm[31:12], in_rd, in_op};
                enc_bad = |in_imm[11:0];
            end
            OP_JAL: begin
                raw_ir  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
                enc_bad = ~imm_j_ok;
            end
            OP_JALR: begin
                raw_ir  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
                enc_bad = ~imm_i_ok;
            end
            OP_LOAD: begin
                raw_ir  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
                enc_bad = ~imm_i_ok || (in_funct3 == 3'b011) || (in_funct3 == 3'b110)
                          || (in_funct3 == 3'b111);
            end
            OP_OPIMM: begin
                if (is_shift) begin
                    raw_ir  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_op};
                    enc_bad = |in_imm[31:5];
                end else begin
                    raw_ir  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
                    enc_bad = ~imm_i_ok;
                end
            end
            OP_STORE: begin
                raw_ir  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
                enc_bad = ~imm_i_ok || (in_funct3 > 3'b010);
            end
            OP_BRANCH: begin
                raw_ir  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_op};
                enc_bad = ~imm_b_ok || (in_funct3 == 3'b010) || (in_funct3 == 3'b011);
            end
            OP_OP: begin
                raw_ir  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
                enc_bad = !((in_funct7 == 7'b0000000) ||
                            ((in_funct7 == 7'b0100000) &&
                             ((in_funct3 == 3'b000) || (in_funct3 == 3'b101))));
            end
            default: enc_bad = 1'b1;
        endcase
        enc_ir = enc_bad ? NOP_IR : raw_ir;
    end

    logic [32:0] mem_q [4];
    logic [32:0] mem_d [4];
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [32:0] head_q, head_d;
    logic [15:0] enc_q, enc_d;
    logic [7:0]  err_q, err_d;
    logic        push;
    logic        pop;

    assign in_ready  = ~rst & (count_q < 3'd4);
    assign out_valid = (count_q != 3'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        err_d    = err_q;
        enc_d    = enc_q + {15'd0, pop};
        if (flush) begin
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
            count_d  = 3'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {enc_bad, enc_ir};
                wr_ptr_d        = wr_ptr_q + 2'd1;
                if (enc_bad && (err_q != 8'hFF)) begin
                    err_d = err_q + 8'd1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            count_d = count_q + {2'b00, push} - {2'b00, pop};
        end
        // The head register only moves when something remains queued, so an
        // empty FIFO keeps presenting the last word it showed.
        if (count_d != 3'd0) begin
            head_d = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            enc_q    <= '0;
            err_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            enc_q    <= enc_d;
            err_q    <= err_d;
        end
    end

    assign out_ir      = head_q[31:0];
    assign out_illegal = head_q[32];
    assign enc_count   = enc_q;
    assign err_count   = err_q;
endmodule
